// File: rtl/gray_ise_pkg.sv
// Shared definitions for the gray-to-RGB565 custom-instruction block.
//   - opcode encodings carried in valueB[1:0]
//   - FSM state encodings
//   - RGB565 field widths
package gray_ise_pkg;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_NEXT   = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

endpackage

// File: rtl/gray_to_rgb565_px.sv
// One gray pixel to RGB565 with a saturating signed brightness offset.
// Purely combinational.
//   gray   : 8-bit gray level
//   offset : signed 8-bit brightness offset (two's complement)
//   rgb    : {R[4:0], G[5:0], B[4:0]}
module gray_to_rgb565_px
  import gray_ise_pkg::*;
(
  input  logic [7:0]       gray,
  input  logic [7:0]       offset,
  output logic [RGB_W-1:0] rgb
);

  // 10 bits covers -128..510 without wrap.
  logic signed [9:0] sum;
  logic        [7:0] g_sat;

  assign sum = $signed({2'b00, gray}) + $signed({{2{offset[7]}}, offset});

  always_comb begin
    g_sat = sum[7:0];
    if (sum < 10'sd0)        g_sat = 8'h00;
    else if (sum > 10'sd255) g_sat = 8'hFF;
  end

  // Replicate the top bits of the gray level into each channel.
  assign rgb = {g_sat[7 -: R_W], g_sat[7 -: G_W], g_sat[7 -: B_W]};

endmodule

// File: rtl/gray_to_rgb565_ise.sv
// Custom-instruction responder: buffers four gray pixels per LOAD and
// returns them two at a time as packed RGB565 with a brightness offset.
//   clock, reset  : clock and async active-low reset
//   start, iseId  : request strobe and instruction id (match required)
//   valueA        : LOAD pixel word, pixel k at [8k+7:8k]
//   valueB        : [1:0] opcode, [15:8] signed offset (LOAD only)
//   done, result  : one-cycle completion strobe and result (0 when idle)
module gray_to_rgb565_ise
  import gray_ise_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q,   state_d;
  logic [1:0]  op_q,      op_d;
  logic [31:0] opa_q,     opa_d;
  logic [7:0]  off_cap_q, off_cap_d;
  logic [31:0] pix_buf_q, pix_buf_d;
  logic [7:0]  off_q,     off_d;
  logic        pending_q, pending_d;
  logic        done_q,    done_d;
  logic [31:0] result_q,  result_d;

  logic unused_valueb;
  assign unused_valueb = ^{valueB[31:16], valueB[7:2]};

  // LOAD converts pair 0 straight from the captured operands; NEXT
  // converts pair 1 from the buffer with the stored offset.
  logic                  use_cap;
  logic [1:0][7:0]       px_gray;
  logic [7:0]            px_off;
  logic [1:0][RGB_W-1:0] px_rgb;

  assign use_cap = (op_q == OP_LOAD);
  assign px_gray = use_cap ? opa_q[15:0] : pix_buf_q[31:16];
  assign px_off  = use_cap ? off_cap_q   : off_q;

  for (genvar j = 0; j < 2; j++) begin : g_px
    gray_to_rgb565_px u_px (
      .gray   (px_gray[j]),
      .offset (px_off),
      .rgb    (px_rgb[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    off_cap_d = off_cap_q;
    pix_buf_d = pix_buf_q;
    off_d     = off_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    result_d  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (start && iseId == customInstructionId) begin
          state_d   = ST_CONV;
          op_d      = valueB[1:0];
          opa_d     = valueA;
          off_cap_d = valueB[15:8];
        end
      end
      ST_CONV: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        case (op_q)
          OP_LOAD: begin
            result_d  = px_rgb;
            pix_buf_d = opa_q;
            off_d     = off_cap_q;
            pending_d = 1'b1;
          end
          OP_NEXT: begin
            if (pending_q) begin
              result_d  = px_rgb;
              pending_d = 1'b0;
            end
          end
          OP_STATUS: result_d = {31'b0, pending_q};
          default:   result_d = 32'h0;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      opa_q     <= 32'h0;
      off_cap_q <= 8'h0;
      pix_buf_q <= 32'h0;
      off_q     <= 8'h0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      off_cap_q <= off_cap_d;
      pix_buf_q <= pix_buf_d;
      off_q     <= off_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
